// File: rtl/rgb_pkg.sv
// Shared constants for the RGB fade sequencer: level width, channel indices
// and FSM state encoding.
package rgb_pkg;

  localparam int LEVEL_W = 8;
  localparam int CH_W    = 2;

  localparam logic [CH_W-1:0] CH_R = 2'd0;
  localparam logic [CH_W-1:0] CH_G = 2'd1;
  localparam logic [CH_W-1:0] CH_B = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CMP   = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;
  localparam logic [1:0] ST_CLAMP = 2'd3;

  // Channel select; any index other than R/G resolves to B.
  function automatic logic [LEVEL_W-1:0] pick_ch(input logic [CH_W-1:0]    ch,
                                                 input logic [LEVEL_W-1:0] r,
                                                 input logic [LEVEL_W-1:0] g,
                                                 input logic [LEVEL_W-1:0] b);
    case (ch)
      CH_R:    pick_ch = r;
      CH_G:    pick_ch = g;
      default: pick_ch = b;
    endcase
  endfunction

endpackage

// File: rtl/rgb_level_bank.sv
// Three brightness level registers plus three latched targets. Levels have one
// indexed write port; targets load together when a pass starts.
module rgb_level_bank
  import rgb_pkg::*;
#(
  parameter logic [LEVEL_W-1:0] INIT_LEVEL = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lvl_we_i,
  input  logic [CH_W-1:0]    lvl_idx_i,
  input  logic [LEVEL_W-1:0] lvl_wdata_i,
  input  logic               tgt_we_i,
  input  logic [LEVEL_W-1:0] tgt_r_i,
  input  logic [LEVEL_W-1:0] tgt_g_i,
  input  logic [LEVEL_W-1:0] tgt_b_i,
  output logic [LEVEL_W-1:0] level_r_o,
  output logic [LEVEL_W-1:0] level_g_o,
  output logic [LEVEL_W-1:0] level_b_o,
  output logic [LEVEL_W-1:0] tgt_r_o,
  output logic [LEVEL_W-1:0] tgt_g_o,
  output logic [LEVEL_W-1:0] tgt_b_o
);

  logic [LEVEL_W-1:0] level_r_q, level_g_q, level_b_q;
  logic [LEVEL_W-1:0] tgt_r_q, tgt_g_q, tgt_b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_r_q <= INIT_LEVEL;
      level_g_q <= INIT_LEVEL;
      level_b_q <= INIT_LEVEL;
    end else if (lvl_we_i) begin
      case (lvl_idx_i)
        CH_R:    level_r_q <= lvl_wdata_i;
        CH_G:    level_g_q <= lvl_wdata_i;
        default: level_b_q <= lvl_wdata_i;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_r_q <= INIT_LEVEL;
      tgt_g_q <= INIT_LEVEL;
      tgt_b_q <= INIT_LEVEL;
    end else if (tgt_we_i) begin
      tgt_r_q <= tgt_r_i;
      tgt_g_q <= tgt_g_i;
      tgt_b_q <= tgt_b_i;
    end
  end

  assign level_r_o = level_r_q;
  assign level_g_o = level_g_q;
  assign level_b_o = level_b_q;
  assign tgt_r_o   = tgt_r_q;
  assign tgt_g_o   = tgt_g_q;
  assign tgt_b_o   = tgt_b_q;

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Ramps R, G, B levels one step toward their targets per tick, sharing a single
// external 8-bit add/subtract ALU across compare, step and clamp phases.
module rgb_fade_sequencer
  import rgb_pkg::*;
#(
  parameter logic [LEVEL_W-1:0] INIT_LEVEL = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [LEVEL_W-1:0] target_r,
  input  logic [LEVEL_W-1:0] target_g,
  input  logic [LEVEL_W-1:0] target_b,
  input  logic [LEVEL_W-1:0] step,
  output logic [LEVEL_W-1:0] alu_a,
  output logic [LEVEL_W-1:0] alu_b,
  output logic               alu_sub,
  input  logic [LEVEL_W-1:0] alu_out,
  input  logic               alu_cout,
  output logic [LEVEL_W-1:0] level_r,
  output logic [LEVEL_W-1:0] level_g,
  output logic [LEVEL_W-1:0] level_b,
  output logic               busy,
  output logic               done,
  output logic               tick_overrun,
  output logic               settled,
  output logic [1:0]         dbg_state
);

  // tick is a one-cycle request with no ready: it is accepted only in IDLE;
  // any tick seen while busy is dropped and flagged on tick_overrun.
  logic [1:0]         state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               dir_q, dir_d;
  logic [LEVEL_W-1:0] temp_q, temp_d;
  logic [LEVEL_W-1:0] step_q, step_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;

  logic               lvl_we, tgt_we, advance;
  logic [LEVEL_W-1:0] lvl_wdata;
  logic [LEVEL_W-1:0] tgt_r, tgt_g, tgt_b;
  logic [LEVEL_W-1:0] cur_level, cur_tgt;

  rgb_level_bank #(.INIT_LEVEL(INIT_LEVEL)) u_bank (
    .clk        (clk),
    .reset      (reset),
    .lvl_we_i   (lvl_we),
    .lvl_idx_i  (ch_q),
    .lvl_wdata_i(lvl_wdata),
    .tgt_we_i   (tgt_we),
    .tgt_r_i    (target_r),
    .tgt_g_i    (target_g),
    .tgt_b_i    (target_b),
    .level_r_o  (level_r),
    .level_g_o  (level_g),
    .level_b_o  (level_b),
    .tgt_r_o    (tgt_r),
    .tgt_g_o    (tgt_g),
    .tgt_b_o    (tgt_b)
  );

  assign cur_level = pick_ch(ch_q, level_r, level_g, level_b);
  assign cur_tgt   = pick_ch(ch_q, tgt_r, tgt_g, tgt_b);

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    dir_d     = dir_q;
    temp_d    = temp_q;
    step_d    = step_q;
    done_d    = 1'b0;
    overrun_d = tick && (state_q != ST_IDLE);
    alu_a     = '0;
    alu_b     = '0;
    alu_sub   = 1'b0;
    lvl_we    = 1'b0;
    lvl_wdata = '0;
    tgt_we    = 1'b0;
    advance   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          tgt_we  = 1'b1;
          step_d  = step;
          ch_d    = CH_R;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        alu_a   = cur_tgt;
        alu_b   = cur_level;
        alu_sub = 1'b1;
        if (alu_out == '0) begin
          advance = 1'b1;
        end else begin
          dir_d   = alu_cout;
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        alu_a   = cur_level;
        alu_b   = step_q;
        alu_sub = !dir_q;
        // Carry out of the add (or borrow of the subtract) means the step ran
        // past the 8-bit range, which is necessarily beyond the target.
        if (dir_q ? alu_cout : !alu_cout) begin
          lvl_we    = 1'b1;
          lvl_wdata = cur_tgt;
          advance   = 1'b1;
        end else begin
          temp_d  = alu_out;
          state_d = ST_CLAMP;
        end
      end
      default: begin
        alu_a     = dir_q ? cur_tgt : temp_q;
        alu_b     = dir_q ? temp_q  : cur_tgt;
        alu_sub   = 1'b1;
        lvl_we    = 1'b1;
        lvl_wdata = alu_cout ? temp_q : cur_tgt;
        advance   = 1'b1;
      end
    endcase

    if (advance) begin
      if (ch_q == CH_B) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        ch_d    = ch_q + 2'd1;
        state_d = ST_CMP;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ch_q      <= CH_R;
      dir_q     <= 1'b0;
      temp_q    <= '0;
      step_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      dir_q     <= dir_d;
      temp_q    <= temp_d;
      step_q    <= step_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign tick_overrun = overrun_q;
  assign settled      = (level_r == tgt_r) && (level_g == tgt_g) && (level_b == tgt_b);
  assign dbg_state    = state_q;

endmodule

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
- Time-multiplexes the single shared 8-bit add/subtract ALU to ramp three LED brightness levels (R, G, B) toward their targets.
- On each `tick`, walks R, then G, then B. Each level moves one `step` toward its target and is clamped so it never overshoots.
- Sits between the colour/target logic and the PWM stage. The ALU is instantiated at top level and driven through this block's `alu_*` ports.

Parameters:
- INIT_LEVEL, 8'h00, reset value of all three levels and of all three latched targets.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  single-cycle request to start one ramp pass.
- target_r, target_g, target_b  in  8 each  desired levels; sampled on the tick that starts a pass.
- step  in  8  ramp increment; sampled with the targets.
- alu_a  out  8  ALU operand A.
- alu_b  out  8  ALU operand B.
- alu_sub  out  1  ALU mode: 0 = A+B, 1 = A-B.
- alu_out  in  8  ALU result, combinational from `alu_a`/`alu_b`/`alu_sub`.
- alu_cout  in  1  add: 1 = unsigned overflow; subtract: 1 = A>=B (no borrow).
- level_r, level_g, level_b  out  8 each  current brightness levels, registered.
- busy  out  1  high while a pass is in progress.
- done  out  1  one-cycle pulse at the end of each pass.
- tick_overrun  out  1  one-cycle pulse when a tick arrives while busy.
- settled  out  1  high when all three levels equal the latched targets.

Behaviour:
- Reset (async, any state):
  - state = IDLE, channel index = R.
  - All levels and latched targets = INIT_LEVEL; latched step = 0.
  - busy = 0, done = 0, tick_overrun = 0.
  - settled = 1.
  - alu_a = 0, alu_b = 0, alu_sub = 0.
- States and transitions:
  - IDLE: on tick, latch the three targets and step, set channel = R, go to CMP. Otherwise stay.
  - CMP: drive A = target[ch], B = level[ch], sub = 1.
    - alu_out == 0 -> channel settled; ADVANCE.
    - Else record dir = alu_cout (1 = up, 0 = down); go to STEP.
  - STEP, dir up: drive A = level[ch], B = step, sub = 0.
    - alu_cout = 1 -> level[ch] = target; ADVANCE.
    - Else store alu_out in a temp register; go to CLAMP.
  - STEP, dir down: drive A = level[ch], B = step, sub = 1.
    - alu_cout = 0 -> level[ch] = target; ADVANCE.
    - Else store temp; go to CLAMP.
  - CLAMP, dir up: drive A = target, B = temp, sub = 1.
    - level[ch] = alu_cout ? temp : target.
  - CLAMP, dir down: drive A = temp, B = target, sub = 1.
    - level[ch] = alu_cout ? temp : target.
    - Then ADVANCE.
  - ADVANCE: not a state; it is an action taken in the same cycle.
    - ch < B -> ch + 1, next state CMP.
    - ch == B -> IDLE, and done = 1 in the next cycle.
- Timing:
  - A settled channel costs 1 cycle; an overflow/underflow channel costs 2; otherwise 3.
  - A pass takes 3 to 9 busy cycles.
- Output timing:
  - busy = (state != IDLE), registered.
  - done is asserted in the first IDLE cycle after a pass.
  - A tick arriving in that same done cycle starts a new pass normally.
- tick while busy: ignored, and tick_overrun pulses in the next cycle. The in-flight pass is unaffected.
- Target or step changes mid-pass have no effect until the next tick.
- step = 0: non-settled channels compute temp = level and write it back unchanged; done still pulses.
- settled: combinational equality of levels against the latched targets.
- alu_* in IDLE: driven to 0/0/0.
- All ALU arithmetic is unsigned 8-bit; no wider intermediates.

Decomposition:
- Shared package `rgb_pkg` holds:
  - state encoding (IDLE, CMP, STEP, CLAMP);
  - channel index constants CH_R = 0, CH_G = 1, CH_B = 2;
  - LEVEL_W = 8.
- One natural sub-module, `rgb_level_bank`: three 8-bit level registers plus three latched targets, with one indexed write port and async reset to INIT_LEVEL.
- The ALU itself stays outside this block.

Test Plan:
1. Reset released -> levels 0, busy 0, done 0, settled 1. A tick with all targets 0 -> 3 busy cycles, done on the 4th cycle, levels unchanged.
2. Targets R = 100, G = 0, B = 255, step = 40, tick at edge 0 -> busy in cycles 1–7, done in cycle 8. After the pass R = 40, G = 0, B = 40, settled 0.
3. Repeat ticks from case 2 -> R sequence 40, 80, 100 (clamped at 100), 100. B sequence 40, 80, …, 240, then 255 via the overflow path (2-cycle channel). settled = 1 after B reaches 255.
4. Levels at 10, target 0, step 40 -> underflow path, level becomes 0 in 2 cycles. Level 100, target 70, step 20 -> 80, then 70 via clamp.
5. Tick asserted in busy cycle 3 -> tick_overrun pulses once and the pass result is unchanged. Targets changed mid-pass -> no effect until the next tick.
6. Reset asserted mid-STEP -> outputs return to reset values immediately (asynchronously). The next tick starts a fresh pass from INIT_LEVEL.
